vga_ddr_rdbuf: RTL and testbench



---
 rtl/vga_ddr_rdbuf_pkg.sv | 29 ++
 rtl/vga_ddr_rdbuf_if.sv | 21 ++
 rtl/vga_ddr_rdbuf_fifo.sv | 85 ++++++++
 rtl/vga_ddr_rdbuf.sv | 169 ++++++++++++++++
 tb/tb_vga_ddr_rdbuf.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_ddr_rdbuf_pkg.sv
// Shared types and defaults for the VGA DDR read-side frame buffer reader.
package vga_buf_pkg;

    localparam int FRAME_WORDS_DEF = 460800;
    localparam int BURST_LEN_DEF   = 64;

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        FILL,
        WAIT,
        DONE
    } bufState_t;

    // One DDR word carries two RGB565 pixels, first pixel in the upper half.
    typedef struct packed {
        logic [15:0] firstPix;
        logic [15:0] secondPix;
    } pixelPair_t;

    // Length of the next burst: a full burst, or whatever is left of the frame.
    function automatic logic [7:0] burstLen(input logic [31:0] wordsLeft, input int maxLen);
        if (wordsLeft > 32'(maxLen)) begin
            return 8'(maxLen);
        end
        return wordsLeft[7:0];
    endfunction

endpackage

// File: rtl/vga_ddr_rdbuf_if.sv
// DDR read port: burst request handshake plus the return-data strobe.
interface vga_ddr_rdbuf_if #(
    parameter int ADDR_W = 24
);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_len;
    logic              rd_ack;
    logic              rd_data_valid;
    logic [31:0]       rd_data;

    modport master (
        output rd_req, rd_addr, rd_len,
        input  rd_ack, rd_data_valid, rd_data
    );

    modport slave (
        input  rd_req, rd_addr, rd_len,
        output rd_ack, rd_data_valid, rd_data
    );
endinterface

// File: rtl/vga_ddr_rdbuf_fifo.sv
// First-word-fall-through FIFO with level output, synchronous flush and
// per-cycle underflow/overflow pulses. The head is a register refreshed from
// storage, so a word pushed into an empty FIFO shows up one cycle later.
module sync_fifo_fwft #(
    parameter int DEPTH = 512,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_pushData,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_underflow,
    output logic                     o_overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rdPtr;
    logic [AW-1:0]    r_wrPtr;
    logic [LW-1:0]    r_level;
    logic [WIDTH-1:0] r_head;

    logic             w_empty;
    logic             w_full;
    logic             w_popOk;
    logic             w_pushOk;
    logic [AW-1:0]    w_rdPtrNext;

    assign w_empty     = (r_level == '0);
    assign w_full      = (r_level == LW'(DEPTH));
    assign w_popOk     = i_pop && !w_empty;
    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign w_pushOk    = i_push && (!w_full || w_popOk);
    assign w_rdPtrNext = r_rdPtr + AW'(1);

    assign o_head      = r_head;
    assign o_level     = r_level;
    assign o_underflow = i_pop && w_empty;
    assign o_overflow  = i_push && w_full && !w_popOk;

    // Storage write port; no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_pushOk && !i_flush) begin
            r_mem[r_wrPtr] <= i_pushData;
        end
    end

    // Pointers, level and head register; head jumps to the next word on a pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_level <= '0;
            r_head  <= '0;
        end else if (i_flush) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_level <= '0;
        end else begin
            if (w_pushOk) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_popOk) begin
                r_rdPtr <= w_rdPtrNext;
            end
            if (w_pushOk && !w_popOk) begin
                r_level <= r_level + LW'(1);
            end else if (w_popOk && !w_pushOk) begin
                r_level <= r_level - LW'(1);
            end
            if (w_popOk) begin
                if (r_level > LW'(1)) begin
                    r_head <= r_mem[w_rdPtrNext];
                end
            end else if (!w_empty) begin
                r_head <= r_mem[r_rdPtr];
            end
        end
    end
endmodule

// File: rtl/vga_ddr_rdbuf.sv
// Frame buffer reader: issues DDR burst reads one at a time while the FIFO
// has room for a full burst, and restarts the frame on each vsync fall.
module vga_ddr_rdbuf
    import vga_buf_pkg::*;
#(
    parameter int                ADDR_W      = 24,
    parameter logic [ADDR_W-1:0] FRAME_BASE  = '0,
    parameter int                FRAME_WORDS = FRAME_WORDS_DEF,
    parameter int                BURST_LEN   = BURST_LEN_DEF,
    parameter int                FIFO_DEPTH  = 512
) (
    input  logic                        vga_clk,
    input  logic                        vga_rst_n,
    input  logic                        ddr_init_done,
    input  logic                        vga_framesync,
    input  logic                        ddr_rden,
    output logic [31:0]                 ddr_data,
    vga_ddr_rdbuf_if.master             ddr,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        underflow,
    output logic                        overflow
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    bufState_t         r_state;
    logic              r_syncPrev;
    logic              r_restart;
    logic              r_rdReq;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_rdLen;
    logic [7:0]        r_burstCnt;
    logic [31:0]       r_wordsLeft;
    logic              r_underflow;
    logic              r_overflow;

    logic              w_fall;
    logic              w_discard;
    logic              w_flush;
    logic              w_push;
    logic              w_fifoUnder;
    logic              w_fifoOver;
    logic              w_roomForBurst;
    logic [LVL_W-1:0]  w_level;
    logic [LVL_W-1:0]  w_space;

    assign w_fall         = r_syncPrev && !vga_framesync && (r_state != IDLE);
    // Words of a burst still in flight when the frame restarts are counted but dropped.
    assign w_discard      = r_restart || w_fall;
    assign w_flush        = (r_state == FLUSH);
    assign w_push         = (r_state == WAIT) && ddr.rd_data_valid && !w_discard;
    assign w_space        = LVL_W'(FIFO_DEPTH) - w_level;
    assign w_roomForBurst = (w_space >= LVL_W'(BURST_LEN));

    assign ddr.rd_req  = r_rdReq;
    assign ddr.rd_addr = r_addr;
    assign ddr.rd_len  = r_rdLen;
    assign fifo_level  = w_level;
    assign underflow   = r_underflow;
    assign overflow    = r_overflow;

    sync_fifo_fwft #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk         (vga_clk),
        .rst_n       (vga_rst_n),
        .i_flush     (w_flush),
        .i_push      (w_push),
        .i_pushData  (ddr.rd_data),
        .i_pop       (ddr_rden),
        .o_head      (ddr_data),
        .o_level     (w_level),
        .o_underflow (w_fifoUnder),
        .o_overflow  (w_fifoOver)
    );

    // Previous vsync level, compared against the live input to find the fall.
    always_ff @(posedge vga_clk or negedge vga_rst_n) begin
        if (!vga_rst_n) begin
            r_syncPrev <= 1'b1;
        end else begin
            r_syncPrev <= vga_framesync;
        end
    end

    // Request FSM: address/word counters, burst counter and registered request.
    always_ff @(posedge vga_clk or negedge vga_rst_n) begin
        if (!vga_rst_n) begin
            r_state     <= IDLE;
            r_rdReq     <= 1'b0;
            r_addr      <= FRAME_BASE;
            r_rdLen     <= '0;
            r_burstCnt  <= '0;
            r_wordsLeft <= '0;
            r_restart   <= 1'b0;
        end else begin
            if (w_fall) begin
                r_restart <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (ddr_init_done) begin
                        r_state <= FLUSH;
                    end
                end
                FLUSH: begin
                    r_addr      <= FRAME_BASE;
                    r_wordsLeft <= 32'(FRAME_WORDS);
                    r_restart   <= w_fall;
                    r_state     <= FILL;
                end
                FILL: begin
                    // A request already on the bus is completed even across a
                    // frame restart; its data is then discarded in WAIT.
                    if (r_rdReq) begin
                        if (ddr.rd_ack) begin
                            r_rdReq     <= 1'b0;
                            r_addr      <= r_addr + ADDR_W'(r_rdLen);
                            r_wordsLeft <= r_wordsLeft - 32'(r_rdLen);
                            r_burstCnt  <= r_rdLen;
                            r_state     <= WAIT;
                        end
                    end else if (w_discard) begin
                        r_state <= FLUSH;
                    end else if (r_wordsLeft == '0) begin
                        r_state <= DONE;
                    end else if (w_roomForBurst) begin
                        r_rdReq <= 1'b1;
                        r_rdLen <= burstLen(r_wordsLeft, BURST_LEN);
                    end
                end
                WAIT: begin
                    if (ddr.rd_data_valid) begin
                        r_burstCnt <= r_burstCnt - 8'd1;
                        if (r_burstCnt == 8'd1) begin
                            r_state <= w_discard ? FLUSH : FILL;
                        end
                    end
                end
                DONE: begin
                    if (w_discard) begin
                        r_state <= FLUSH;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Sticky error flags, cleared when a new frame is flushed in.
    always_ff @(posedge vga_clk or negedge vga_rst_n) begin
        if (!vga_rst_n) begin
            r_underflow <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (w_flush) begin
            r_underflow <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_fifoUnder) begin
                r_underflow <= 1'b1;
            end
            if (w_fifoOver) begin
                r_overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_vga_ddr_rdbuf.sv
// Directed bench for vga_ddr_rdbuf. The bench plays the DDR controller by hand
// (request, ack three cycles later, return data) and the display (pops).
// Frame is 600 words so the 512-word FIFO prefills in 8 bursts and the frame
// tail then comes out as bursts of 64 and 24.
module tb_vga_ddr_rdbuf;

    localparam logic [23:0] BASE = 24'h000100;

    logic        vgaClk;
    logic        vgaRstN;
    logic        ddrInitDone;
    logic        vgaFramesync;
    logic        ddrRden;
    logic [31:0] ddrData;
    logic [9:0]  fifoLevel;
    logic        underflow;
    logic        overflow;

    int          checksTotal;
    int          checksPassed;
    int          popErrors;
    logic [23:0] popAddr;
    logic        seenReq;

    vga_ddr_rdbuf_if #(.ADDR_W(24)) ddr ();

    vga_ddr_rdbuf #(
        .ADDR_W      (24),
        .FRAME_BASE  (BASE),
        .FRAME_WORDS (600),
        .BURST_LEN   (64),
        .FIFO_DEPTH  (512)
    ) dut (
        .vga_clk       (vgaClk),
        .vga_rst_n     (vgaRstN),
        .ddr_init_done (ddrInitDone),
        .vga_framesync (vgaFramesync),
        .ddr_rden      (ddrRden),
        .ddr_data      (ddrData),
        .ddr           (ddr),
        .fifo_level    (fifoLevel),
        .underflow     (underflow),
        .overflow      (overflow)
    );

    // Free-running clock, 10 ns period; inputs change and outputs are sampled on negedge.
    initial begin
        vgaClk = 1'b0;
        forever #5 vgaClk = ~vgaClk;
    end

    // Safety net so a stuck run still terminates with a visible failure.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: run did not finish, checks so far %0d", checksTotal);
        $fatal(1, "[TB] watchdog expired");
    end

    // Word the DDR model returns for a given address.
    function automatic logic [31:0] wordAt(input logic [23:0] addr);
        return {8'h5A, addr};
    endfunction

    // Single comparison point: counts every check and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checksTotal++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end else begin
            checksPassed++;
        end
    endtask

    // Drive one cycle of display pop / DDR return inputs.
    task automatic applyStimulus(input logic rden, input logic dataValid, input logic [31:0] data);
        ddrRden           = rden;
        ddr.rd_data_valid = dataValid;
        ddr.rd_data       = data;
        @(negedge vgaClk);
        ddrRden           = 1'b0;
        ddr.rd_data_valid = 1'b0;
    endtask

    // Idle for n cycles, noting whether any request appeared.
    task automatic idleCycles(input int n, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (ddr.rd_req) seen = 1'b1;
            applyStimulus(1'b0, 1'b0, 32'h0);
        end
    endtask

    // Wait (bounded) for a request and check its address and length.
    task automatic expectReq(input string tag, input logic [23:0] expAddr, input logic [7:0] expLen);
        int waited;
        waited = 0;
        while (!ddr.rd_req && waited < 300) begin
            applyStimulus(1'b0, 1'b0, 32'h0);
            waited++;
        end
        checkOutput({tag, ".seen"}, 64'(ddr.rd_req), 64'd1);
        checkOutput({tag, ".addr"}, 64'(ddr.rd_addr), 64'(expAddr));
        checkOutput({tag, ".len"}, 64'(ddr.rd_len), 64'(expLen));
    endtask

    // Accept the pending request three cycles after it was seen.
    task automatic ackReq();
        applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        ddr.rd_ack = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0);
        ddr.rd_ack = 1'b0;
        checkOutput("reqDropAfterAck", 64'(ddr.rd_req), 64'd0);
    endtask

    // Return n consecutive words starting at base.
    task automatic sendWords(input logic [23:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus(1'b0, 1'b1, wordAt(base + 24'(k)));
        end
    endtask

    // Pop n words, tallying any that are out of the expected address order.
    task automatic popWords(input int n);
        for (int k = 0; k < n; k++) begin
            if (ddrData !== wordAt(popAddr)) popErrors++;
            applyStimulus(1'b1, 1'b0, 32'h0);
            popAddr = popAddr + 24'd1;
        end
    endtask

    // Main directed sequence.
    initial begin
        checksTotal       = 0;
        checksPassed      = 0;
        popErrors         = 0;
        popAddr           = BASE;
        vgaRstN           = 1'b0;
        ddrInitDone       = 1'b0;
        vgaFramesync      = 1'b1;
        ddrRden           = 1'b0;
        ddr.rd_ack        = 1'b0;
        ddr.rd_data_valid = 1'b0;
        ddr.rd_data       = 32'h0;
        repeat (3) @(negedge vgaClk);

        $display("[TB] reset values");
        checkOutput("rstReq", 64'(ddr.rd_req), 64'd0);
        checkOutput("rstAddr", 64'(ddr.rd_addr), 64'(BASE));
        checkOutput("rstLen", 64'(ddr.rd_len), 64'd0);
        checkOutput("rstData", 64'(ddrData), 64'd0);
        checkOutput("rstLevel", 64'(fifoLevel), 64'd0);
        checkOutput("rstUnderflow", 64'(underflow), 64'd0);
        checkOutput("rstOverflow", 64'(overflow), 64'd0);
        vgaRstN = 1'b1;

        $display("[TB] init held low, underflow while empty");
        idleCycles(50, seenReq);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("idleUnderflow", 64'(underflow), 64'd1);
        checkOutput("idleUnderflowData", 64'(ddrData), 64'd0);
        checkOutput("idleUnderflowLevel", 64'(fifoLevel), 64'd0);
        begin
            logic seenLater;
            idleCycles(50, seenLater);
            checkOutput("noReqBeforeInit", 64'(seenReq | seenLater), 64'd0);
        end

        $display("[TB] prefill");
        ddrInitDone = 1'b1;
        expectReq("frame1Req0", BASE, 8'd64);
        checkOutput("underflowClearedAtStart", 64'(underflow), 64'd0);
        for (int b = 0; b < 8; b++) begin
            if (b > 0) expectReq("prefillReq", BASE + 24'(64 * b), 8'd64);
            ackReq();
            sendWords(BASE + 24'(64 * b), 64);
        end
        idleCycles(50, seenReq);
        checkOutput("noNinthReq", 64'(seenReq), 64'd0);
        checkOutput("prefillLevel", 64'(fifoLevel), 64'd512);
        checkOutput("prefillOverflow", 64'(overflow), 64'd0);
        checkOutput("prefillHead", 64'(ddrData), 64'(wordAt(BASE)));

        $display("[TB] frame tail");
        popWords(153);
        expectReq("tailReq64", BASE + 24'd512, 8'd64);
        ackReq();
        sendWords(BASE + 24'd512, 64);
        expectReq("tailReq24", BASE + 24'd576, 8'd24);
        ackReq();
        sendWords(BASE + 24'd576, 24);
        idleCycles(50, seenReq);
        checkOutput("noReqAfterDone", 64'(seenReq), 64'd0);
        checkOutput("tailLevel", 64'(fifoLevel), 64'd447);
        checkOutput("tailPopOrder", 64'(popErrors), 64'd0);
        checkOutput("tailHead", 64'(ddrData), 64'(wordAt(popAddr)));

        $display("[TB] frame sync mid-burst");
        vgaFramesync = 1'b0;
        repeat (3) applyStimulus(1'b0, 1'b0, 32'h0);
        vgaFramesync = 1'b1;
        expectReq("frame2Req0", BASE, 8'd64);
        checkOutput("frame2FlushLevel", 64'(fifoLevel), 64'd0);
        ackReq();
        sendWords(BASE, 10);
        checkOutput("midLevel", 64'(fifoLevel), 64'd10);
        checkOutput("midHead", 64'(ddrData), 64'(wordAt(BASE)));
        vgaFramesync = 1'b0;
        repeat (2) applyStimulus(1'b0, 1'b0, 32'h0);
        vgaFramesync = 1'b1;
        sendWords(BASE + 24'd10, 54);
        checkOutput("discardLevel", 64'(fifoLevel), 64'd10);
        expectReq("frame3Req0", BASE, 8'd64);
        checkOutput("frame3FlushLevel", 64'(fifoLevel), 64'd0);

        $display("[TB] simultaneous push and pop");
        ackReq();
        sendWords(BASE, 5);
        checkOutput("pushPopPreLevel", 64'(fifoLevel), 64'd5);
        checkOutput("pushPopPreHead", 64'(ddrData), 64'(wordAt(BASE)));
        applyStimulus(1'b1, 1'b1, wordAt(BASE + 24'd5));
        checkOutput("pushPopLevel", 64'(fifoLevel), 64'd5);
        checkOutput("pushPopHead", 64'(ddrData), 64'(wordAt(BASE + 24'd1)));
        sendWords(BASE + 24'd6, 58);
        checkOutput("burstDoneLevel", 64'(fifoLevel), 64'd63);
        popAddr   = BASE + 24'd1;
        popErrors = 0;
        popWords(63);
        checkOutput("frame3PopOrder", 64'(popErrors), 64'd0);
        checkOutput("drainedLevel", 64'(fifoLevel), 64'd0);
        checkOutput("drainedHead", 64'(ddrData), 64'(wordAt(BASE + 24'd63)));

        $display("[TB] underflow with data held");
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("underflowSet", 64'(underflow), 64'd1);
        checkOutput("underflowHeldData", 64'(ddrData), 64'(wordAt(BASE + 24'd63)));
        checkOutput("underflowLevel", 64'(fifoLevel), 64'd0);
        expectReq("frame3Req1", BASE + 24'd64, 8'd64);
        ackReq();
        applyStimulus(1'b1, 1'b1, wordAt(BASE + 24'd64));
        checkOutput("emptyPushPopLevel", 64'(fifoLevel), 64'd1);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("emptyPushPopHead", 64'(ddrData), 64'(wordAt(BASE + 24'd64)));

        $display("[TB] underflow clears at frame start");
        vgaFramesync = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0);
        vgaFramesync = 1'b1;
        sendWords(BASE + 24'd65, 63);
        expectReq("frame4Req0", BASE, 8'd64);
        checkOutput("underflowCleared", 64'(underflow), 64'd0);
        checkOutput("frame4Level", 64'(fifoLevel), 64'd0);
        checkOutput("frame4Overflow", 64'(overflow), 64'd0);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
